// File: rtl/branch_predictor_1bit.sv
// branch_predictor_1bit
//
// Fetch-side 1-bit direction predictor with a direct-mapped branch target
// buffer. Predictions ride a DEPTH-long delay line alongside the fetched PC
// and are checked against the resolved outcome when they reach execute.
// A mispredict produces a registered one-cycle MISS pulse plus the correct
// next PC, and flushes every wrong-path entry still in the delay line.
//
// Build option:
//   BP_BTB_TAG_EN  - when defined, each BTB entry stores a PC tag and a hit
//                    requires a tag match. When undefined, there is no tag
//                    storage and a valid entry hits for every PC that maps
//                    to its index (aliasing PCs share one entry).

module branch_predictor_1bit #(
  parameter int ENTRIES = 16,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        CLOCK,
  input  logic        INIT,
  input  logic        STALL,
  input  logic [31:0] FETCH_PC,
  input  logic        FETCH_VALID,
  output logic        PREDICT_TAKEN,
  output logic [31:0] PREDICT_TARGET,
  input  logic        RESOLVE_VALID,
  input  logic        RESOLVE_TAKEN,
  input  logic [31:0] RESOLVE_TARGET,
  input  logic [31:0] RESOLVE_PC,
  output logic        MISS,
  output logic [31:0] REDIRECT_PC
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int HEAD  = DEPTH - 1;

  // ---------------------------------------------------------------------
  // PC field helpers
  // ---------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

`ifdef BP_BTB_TAG_EN
  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[IDX_W+2+TAG_W-1:IDX_W+2];
  endfunction
`endif

  // ---------------------------------------------------------------------
  // BTB storage
  // ---------------------------------------------------------------------
  logic [ENTRIES-1:0] btb_valid_r;
  logic [ENTRIES-1:0] btb_dir_r;
  logic [31:0]        btb_target_r [ENTRIES];
`ifdef BP_BTB_TAG_EN
  logic [TAG_W-1:0]   btb_tag_r    [ENTRIES];
`endif

  // ---------------------------------------------------------------------
  // Delay line: slot 0 is the youngest fetch, slot HEAD sits at execute
  // ---------------------------------------------------------------------
  logic [DEPTH-1:0] dl_v_r;
  logic [DEPTH-1:0] dl_ptaken_r;
  logic [31:0]      dl_pc_r      [DEPTH];
  logic [31:0]      dl_ptarget_r [DEPTH];

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] fetch_idx_s;
  logic             fetch_hit_s;
  logic             predict_taken_s;
  logic [31:0]      predict_target_s;

  logic [31:0]      head_pc_s;
  logic             head_ptaken_s;
  logic [31:0]      head_ptarget_s;
  logic             mismatch_s;
  logic             alias_miss_s;
  logic [31:0]      redirect_s;

  logic             btb_wr_en_s;
  logic [IDX_W-1:0] btb_wr_idx_s;
  logic             btb_inval_en_s;
  logic [IDX_W-1:0] btb_inval_idx_s;

  logic             miss_r;
  logic [31:0]      redirect_pc_r;

  assign head_pc_s      = dl_pc_r[HEAD];
  assign head_ptaken_s  = dl_ptaken_r[HEAD];
  assign head_ptarget_s = dl_ptarget_r[HEAD];

  // Lookup of the fetch PC against the BTB; sees pre-write contents this cycle
  always_comb begin
    fetch_idx_s      = pc_index(FETCH_PC);
    fetch_hit_s      = 1'b0;
    predict_taken_s  = 1'b0;
    predict_target_s = 32'd0;
`ifdef BP_BTB_TAG_EN
    fetch_hit_s = btb_valid_r[fetch_idx_s] &
                  (btb_tag_r[fetch_idx_s] == pc_tag(FETCH_PC));
`else
    fetch_hit_s = btb_valid_r[fetch_idx_s];
`endif
    if (fetch_hit_s && btb_dir_r[fetch_idx_s]) begin
      predict_taken_s  = 1'b1;
      predict_target_s = btb_target_r[fetch_idx_s];
    end else begin
      predict_taken_s  = 1'b0;
      predict_target_s = 32'd0;
    end
  end

  assign PREDICT_TAKEN  = predict_taken_s;
  assign PREDICT_TARGET = predict_target_s;

  // Compare the head-of-line prediction with the execute-stage outcome
  always_comb begin
    mismatch_s   = 1'b0;
    alias_miss_s = 1'b0;
    redirect_s   = head_pc_s + 32'd4;
    if (!STALL && dl_v_r[HEAD]) begin
      if (RESOLVE_VALID) begin
        mismatch_s = (head_ptaken_s != RESOLVE_TAKEN) |
                     (RESOLVE_TAKEN & (head_ptarget_s != RESOLVE_TARGET));
      end else begin
        // Predicted taken on something that is not a branch at all
        mismatch_s   = head_ptaken_s;
        alias_miss_s = head_ptaken_s;
      end
    end else begin
      mismatch_s   = 1'b0;
      alias_miss_s = 1'b0;
    end
    if (RESOLVE_VALID && RESOLVE_TAKEN) begin
      redirect_s = RESOLVE_TARGET;
    end else begin
      redirect_s = head_pc_s + 32'd4;
    end
  end

  // Decide which BTB entry (if any) is trained or invalidated this cycle
  always_comb begin
    btb_wr_en_s     = 1'b0;
    btb_wr_idx_s    = pc_index(RESOLVE_PC);
    btb_inval_en_s  = 1'b0;
    btb_inval_idx_s = pc_index(head_pc_s);
    if (!STALL && RESOLVE_VALID) begin
      btb_wr_en_s = 1'b1;
    end else if (!STALL && alias_miss_s) begin
      btb_inval_en_s = 1'b1;
    end else begin
      btb_wr_en_s    = 1'b0;
      btb_inval_en_s = 1'b0;
    end
  end

  // BTB valid and direction bits; INIT wipes every valid bit
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      btb_valid_r <= {ENTRIES{1'b0}};
    end else if (btb_wr_en_s) begin
      btb_valid_r[btb_wr_idx_s] <= 1'b1;
      btb_dir_r[btb_wr_idx_s]   <= RESOLVE_TAKEN;
    end else if (btb_inval_en_s) begin
      btb_valid_r[btb_inval_idx_s] <= 1'b0;
    end
  end

  // BTB payload: target only follows taken outcomes, tag follows every write
  always_ff @(posedge CLOCK) begin
    if (!INIT && btb_wr_en_s) begin
      if (RESOLVE_TAKEN) begin
        btb_target_r[btb_wr_idx_s] <= RESOLVE_TARGET;
      end
`ifdef BP_BTB_TAG_EN
      btb_tag_r[btb_wr_idx_s] <= pc_tag(RESOLVE_PC);
`endif
    end
  end

  // Delay-line valid bits: shift when running, wipe on mispredict or INIT
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      dl_v_r <= {DEPTH{1'b0}};
    end else if (!STALL) begin
      for (int i = HEAD; i > 32'sd0; i--) begin
        dl_v_r[i] <= dl_v_r[i - 32'sd1] & ~mismatch_s;
      end
      dl_v_r[0] <= FETCH_VALID & ~mismatch_s;
    end
  end

  // Delay-line payload moves in lockstep with the valid bits
  always_ff @(posedge CLOCK) begin
    if (!STALL) begin
      for (int i = HEAD; i > 32'sd0; i--) begin
        dl_pc_r[i]      <= dl_pc_r[i - 32'sd1];
        dl_ptaken_r[i]  <= dl_ptaken_r[i - 32'sd1];
        dl_ptarget_r[i] <= dl_ptarget_r[i - 32'sd1];
      end
      dl_pc_r[0]      <= FETCH_PC;
      dl_ptaken_r[0]  <= predict_taken_s;
      dl_ptarget_r[0] <= predict_target_s;
    end
  end

  // Registered mispredict pulse and redirect PC; a stall forces MISS low
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      miss_r        <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      miss_r <= mismatch_s;
      if (mismatch_s) begin
        redirect_pc_r <= redirect_s;
      end
    end
  end

  assign MISS        = miss_r;
  assign REDIRECT_PC = redirect_pc_r;

endmodule

// File: tb/tb_branch_predictor_1bit.sv
// Directed bench for branch_predictor_1bit (ENTRIES=16, DEPTH=2, TAG_W=8).
// Expected values are worked out by hand from the predictor's behaviour.
`timescale 1ns/1ps

module tb_branch_predictor_1bit;

`ifdef BP_BTB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        INIT;
  logic        STALL;
  logic [31:0] FETCH_PC;
  logic        FETCH_VALID;
  logic        PREDICT_TAKEN;
  logic [31:0] PREDICT_TARGET;
  logic        RESOLVE_VALID;
  logic        RESOLVE_TAKEN;
  logic [31:0] RESOLVE_TARGET;
  logic [31:0] RESOLVE_PC;
  logic        MISS;
  logic [31:0] REDIRECT_PC;

  int errors = 0;
  int checks = 0;

  branch_predictor_1bit #(
    .ENTRIES(16),
    .DEPTH(2),
    .TAG_W(8)
  ) dut (
    .CLOCK(CLOCK),
    .INIT(INIT),
    .STALL(STALL),
    .FETCH_PC(FETCH_PC),
    .FETCH_VALID(FETCH_VALID),
    .PREDICT_TAKEN(PREDICT_TAKEN),
    .PREDICT_TARGET(PREDICT_TARGET),
    .RESOLVE_VALID(RESOLVE_VALID),
    .RESOLVE_TAKEN(RESOLVE_TAKEN),
    .RESOLVE_TARGET(RESOLVE_TARGET),
    .RESOLVE_PC(RESOLVE_PC),
    .MISS(MISS),
    .REDIRECT_PC(REDIRECT_PC)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    INIT           = 1'b0;
    STALL          = 1'b0;
    FETCH_VALID    = 1'b0;
    FETCH_PC       = 32'd0;
    RESOLVE_VALID  = 1'b0;
    RESOLVE_TAKEN  = 1'b0;
    RESOLVE_TARGET = 32'd0;
    RESOLVE_PC     = 32'd0;
  endtask

  task automatic chk_pred(input string tag, input logic ept, input logic [31:0] eptgt);
    #1;
    chk({tag, ".ptaken"}, {31'd0, PREDICT_TAKEN}, {31'd0, ept});
    chk({tag, ".ptarget"}, PREDICT_TARGET, eptgt);
  endtask

  // One isolated branch: fetch, bubble, resolve, then one idle cycle
  task automatic br(input string tag, input logic [31:0] pc, input logic rt,
                    input logic [31:0] rtgt, input logic ept, input logic [31:0] eptgt,
                    input logic emiss, input logic [31:0] eredir);
    idle(); FETCH_VALID = 1'b1; FETCH_PC = pc;
    chk_pred(tag, ept, eptgt);
    tick();
    idle(); tick();
    idle(); RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = rt; RESOLVE_TARGET = rtgt; RESOLVE_PC = pc;
    tick();
    chk({tag, ".miss"}, {31'd0, MISS}, {31'd0, emiss});
    if (emiss) chk({tag, ".redirect"}, REDIRECT_PC, eredir);
    idle(); tick();
    chk({tag, ".miss_drop"}, {31'd0, MISS}, 32'd0);
  endtask

  initial begin
    // Reset
    idle(); INIT = 1'b1;
    tick(); tick();
    idle();
    chk("rst.miss", {31'd0, MISS}, 32'd0);
    chk("rst.redirect", REDIRECT_PC, 32'd0);

    // Cold miss, training, steady state, direction flip
    br("cold",  32'h100, 1'b1, 32'h140, 1'b0, 32'h0,   1'b1, 32'h140);
    br("tk1",   32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0);
    br("tk2",   32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0);
    br("tk3",   32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0);
    br("nt",    32'h100, 1'b0, 32'h0,   1'b1, 32'h140, 1'b1, 32'h104);
    br("nt2",   32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    br("retk",  32'h100, 1'b1, 32'h140, 1'b0, 32'h0,   1'b1, 32'h140);
    br("newtg", 32'h100, 1'b1, 32'h180, 1'b1, 32'h140, 1'b1, 32'h180);
    br("tg180", 32'h100, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h0);

    // Miss at head with two younger fetches in flight
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h100;
    chk_pred("fl.f0", 1'b1, 32'h180);
    tick();
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h108;
    chk_pred("fl.f1", 1'b0, 32'h0);
    tick();
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h10C;
    RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b0; RESOLVE_PC = 32'h100;
    tick();
    chk("fl.miss", {31'd0, MISS}, 32'd1);
    chk("fl.redirect", REDIRECT_PC, 32'h104);
    idle(); RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b1; RESOLVE_TARGET = 32'h300; RESOLVE_PC = 32'h108;
    tick();
    chk("fl.young1", {31'd0, MISS}, 32'd0);
    idle(); RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b1; RESOLVE_TARGET = 32'h300; RESOLVE_PC = 32'h10C;
    tick();
    chk("fl.young2", {31'd0, MISS}, 32'd0);
    idle(); FETCH_PC = 32'h108;
    chk_pred("fl.trained", 1'b1, 32'h300);
    tick();
    chk("fl.idle", {31'd0, MISS}, 32'd0);

    // Stall held for three cycles over the resolving branch
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h100;
    chk_pred("st.f", 1'b0, 32'h0);
    tick();
    idle(); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); STALL = 1'b1;
      RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b1; RESOLVE_TARGET = 32'h140; RESOLVE_PC = 32'h100;
      tick();
      chk("st.held", {31'd0, MISS}, 32'd0);
    end
    idle(); RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b1; RESOLVE_TARGET = 32'h140; RESOLVE_PC = 32'h100;
    tick();
    chk("st.miss", {31'd0, MISS}, 32'd1);
    chk("st.redirect", REDIRECT_PC, 32'h140);
    idle(); tick();
    chk("st.drop", {31'd0, MISS}, 32'd0);

    // Alias: 0x140 shares index 0 with 0x100 (trained taken to 0x140)
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h140;
    chk_pred("al.f", ~TAG_EN, TAG_EN ? 32'h0 : 32'h140);
    tick();
    idle(); tick();
    idle(); RESOLVE_PC = 32'h140;
    tick();
    chk("al.miss", {31'd0, MISS}, {31'd0, ~TAG_EN});
    chk("al.redirect", REDIRECT_PC, TAG_EN ? 32'h140 : 32'h144);
    idle(); FETCH_PC = 32'h100;
    chk_pred("al.after", TAG_EN, TAG_EN ? 32'h140 : 32'h0);
    tick();
    chk("al.drop", {31'd0, MISS}, 32'd0);

    // INIT while a mispredicted branch is resolving
    idle(); FETCH_VALID = 1'b1; FETCH_PC = 32'h108;
    chk_pred("in.f", 1'b1, 32'h300);
    tick();
    idle(); tick();
    idle(); INIT = 1'b1;
    RESOLVE_VALID = 1'b1; RESOLVE_TAKEN = 1'b0; RESOLVE_PC = 32'h108;
    tick();
    chk("in.miss", {31'd0, MISS}, 32'd0);
    chk("in.redirect", REDIRECT_PC, 32'h0);
    idle(); FETCH_PC = 32'h108;
    chk_pred("in.cleared", 1'b0, 32'h0);
    tick();
    chk("in.idle", {31'd0, MISS}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_1bit.md
# branch_predictor_1bit

Fetch-side 1-bit branch predictor with branch target buffer for the RV32IM pipeline. It predicts direction and target for each fetched PC and tracks predictions in flight to the execute stage. At execute it compares each prediction against the resolved outcome. It emits a one-cycle MISS pulse with a redirect PC, which drives the pipeline flush and the miss-statistics counter's MISS input.

## Interface
- ENTRIES, 16: BTB entries (power of two); index = FETCH_PC[IDX_W+1:2], IDX_W = log2(ENTRIES)
- DEPTH, 2: fetch-to-execute distance in stages; also the delay-line length
- TAG_W, 8: tag bits taken from PC[IDX_W+2+TAG_W-1:IDX_W+2]
- CLOCK  in  1  rising-edge clock
- INIT  in  1  synchronous active-high reset
- STALL  in  1  pipeline frozen this cycle
- FETCH_PC  in  32  PC presented by fetch this cycle
- FETCH_VALID  in  1  FETCH_PC is a real fetch, not a bubble
- PREDICT_TAKEN  out  1  combinational prediction for FETCH_PC
- PREDICT_TARGET  out  32  combinational predicted target; 0 when PREDICT_TAKEN=0
- RESOLVE_VALID  in  1  execute holds a branch/jump this cycle
- RESOLVE_TAKEN  in  1  actual direction
- RESOLVE_TARGET  in  32  actual target, meaningful when RESOLVE_TAKEN=1
- RESOLVE_PC  in  32  PC of the resolving instruction
- MISS  out  1  registered one-cycle mispredict pulse
- REDIRECT_PC  out  32  registered correct next PC, valid while MISS=1

## Operation
- BTB entry: valid, tag, dir bit, 32-bit target. All valid bits clear on INIT.
- Lookup, combinational: hit = valid & tag match. PREDICT_TAKEN = hit & dir. PREDICT_TARGET = target when PREDICT_TAKEN=1, else 0. Lookup ignores STALL.
- Delay line: DEPTH slots of {v, pc, ptaken, ptarget}. On each cycle with !STALL it shifts, and slot 0 loads {FETCH_VALID, FETCH_PC, PREDICT_TAKEN, PREDICT_TARGET}. The head slot (DEPTH-1) is aligned with execute.
- Check, evaluated only when !STALL and head.v=1:
  - If RESOLVE_VALID=1: mismatch = (ptaken != RESOLVE_TAKEN) | (RESOLVE_TAKEN & ptarget != RESOLVE_TARGET).
  - If RESOLVE_VALID=0: mismatch = ptaken (alias hit on a non-branch).
- On mismatch, next cycle: MISS=1 and REDIRECT_PC = RESOLVE_TAKEN ? RESOLVE_TARGET : head.pc+4. A non-branch mismatch uses head.pc+4.
- Flush: on the same edge that sets MISS, every delay-line slot's v clears, discarding wrong-path fetches, and slot 0 loads v=0.
- Update, when !STALL and RESOLVE_VALID=1, regardless of head.v: entry[RESOLVE_PC index] gets valid=1, tag, dir=RESOLVE_TAKEN, and target=RESOLVE_TARGET only if taken (otherwise target unchanged).
- A non-branch alias hit (RESOLVE_VALID=0 with mismatch) clears that entry's valid bit.
- Same-cycle update and lookup of one index: lookup returns the old contents; the write lands at the edge.

## Timing
- Reset values: MISS=0, REDIRECT_PC=0, all delay-line v=0, all BTB valid=0. PREDICT_TAKEN is therefore 0 the cycle after INIT.
- INIT has priority over STALL and resolve, including mid-flight: no MISS is produced for instructions resolving in the INIT cycle.
- Prediction latency is 0 cycles. Miss latency is 1 cycle after the resolve edge, and MISS is high for exactly one cycle.
- STALL=1: no shift, no check, no BTB write. MISS still drops to 0, so a stalled resolve is never double-counted.
- Back-to-back misses in consecutive resolve cycles cannot occur, because the flush invalidates the head. The first resolve after a flush arrives at least DEPTH cycles later.

## Configuration
- BP_BTB_TAG_EN defined: tags are stored and compared as above.
- BP_BTB_TAG_EN undefined: no tag storage, hit = valid only (aliasing PCs share entries), and tag update logic is removed.

## Test plan
- INIT, then fetch PC=0x100 with a BEQ resolving taken to 0x140 after DEPTH cycles -> MISS=1 for 1 cycle with REDIRECT_PC=0x140; the next fetch of 0x100 gives PREDICT_TAKEN=1, PREDICT_TARGET=0x140.
- Repeat 0x100 taken three times -> MISS=0 each time. Then resolve it not-taken -> MISS=1, REDIRECT_PC=0x104, and the next prediction is not-taken.
- Taken with a changed target (0x140 to 0x180) -> MISS=1, REDIRECT_PC=0x180, and the BTB target is updated.
- Miss at head with younger fetches in flight -> all slots invalid after the flush, and no MISS on their resolve cycles.
- Assert STALL during the resolve cycle for 3 cycles -> MISS stays 0 until the stall drops, then a single 1-cycle pulse.
- Aliasing, with the macro defined: 0x100 trained taken, then 0x100+(ENTRIES·4) fetched -> PREDICT_TAKEN=0. Without the macro -> PREDICT_TAKEN=1; its non-branch resolve gives MISS=1 with REDIRECT_PC=pc+4 and the entry is invalidated.
